// File: rtl/pong_pkg.sv
// Shared types and screen/keypad constants for the pong paddle logic.
`timescale 1ns/1ps
package pong_pkg;

    localparam int Y_W   = 10;
    localparam int KEY_W = 5;

    localparam logic [KEY_W-1:0] DEF_KEY_UP    = 5'd2;
    localparam logic [KEY_W-1:0] DEF_KEY_DOWN  = 5'd8;
    localparam logic [KEY_W-1:0] DEF_KEY_SERVE = 5'd5;

    localparam int DEF_Y_BOTTOM = 480;
    localparam int DEF_PADDLE_H = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_state_e;

    typedef struct packed {
        logic             present;
        logic [KEY_W-1:0] code;
    } key_code_t;

    // A released keypad reports "none" regardless of what the keycode bus holds.
    function automatic key_code_t mk_key(input logic flag, input logic [KEY_W-1:0] code);
        key_code_t k;
        k.present = flag;
        k.code    = flag ? code : '0;
        return k;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Generic debouncer: a value must be stable for CYCLES clocks before it is accepted.
`timescale 1ns/1ps
module key_debounce #(
    parameter int W      = 6,
    parameter int CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] dout_next
);

    localparam int                CNT_W   = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ACC = CNT_W'(CYCLES - 2);

    logic [W-1:0]     cand;
    logic [CNT_W-1:0] cnt;

    // Accept on the edge where the counter steps to CYCLES-1, giving exactly CYCLES clocks of latency.
    always_comb begin
        dout_next = dout;
        if (din == cand && cnt >= CNT_ACC)
            dout_next = cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            dout <= dout_next;
            if (din != cand) begin
                cand <= din;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: debounced keypad -> clamped, accelerating paddle_y plus serve pulse.
`timescale 1ns/1ps
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter logic [KEY_W-1:0] KEY_UP          = DEF_KEY_UP,
    parameter logic [KEY_W-1:0] KEY_DOWN        = DEF_KEY_DOWN,
    parameter logic [KEY_W-1:0] KEY_SERVE       = DEF_KEY_SERVE,
    parameter int               Y_TOP           = 0,
    parameter int               Y_BOTTOM        = DEF_Y_BOTTOM,
    parameter int               PADDLE_H        = DEF_PADDLE_H,
    parameter int               Y_RESET         = 208,
    parameter int               SPEED_MIN       = 2,
    parameter int               SPEED_MAX       = 8,
    parameter int               ACCEL_FRAMES    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4:0]     keycode,
    input  logic           key_flag,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y,
    output logic           moving_up,
    output logic           moving_down,
    output logic           serve_pulse
);

    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int FC_W  = (ACCEL_FRAMES > 2) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [SPD_W-1:0]     SPD_MIN_V = SPD_W'(SPEED_MIN);
    localparam logic [SPD_W-1:0]     SPD_MAX_V = SPD_W'(SPEED_MAX);
    localparam logic [FC_W-1:0]      FC_LAST   = FC_W'(ACCEL_FRAMES - 1);
    localparam logic signed [Y_W:0]  Y_TOP_S   = (Y_W+1)'(Y_TOP);
    localparam logic signed [Y_W:0]  Y_MAX_S   = (Y_W+1)'(Y_BOTTOM - PADDLE_H);

    key_code_t raw, acc_q, acc_d;

    assign raw = mk_key(key_flag, keycode);

    key_debounce #(
        .W      ($bits(key_code_t)),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .din       (raw),
        .dout      (acc_q),
        .dout_next (acc_d)
    );

    paddle_state_e    state_q, state_d;
    logic [SPD_W-1:0] spd_q, spd_d, spd_base;
    logic [FC_W-1:0]  fcnt_q, fcnt_d, fcnt_base;
    logic [Y_W-1:0]   y_d;
    logic signed [Y_W:0] y_up, y_dn;
    logic             serve_d;

    // State is derived from the debouncer's next value so it loads on the same edge as the accepted code.
    always_comb begin
        state_d = IDLE;
        if (acc_d.present && acc_d.code == KEY_UP)
            state_d = UP;
        else if (acc_d.present && acc_d.code == KEY_DOWN)
            state_d = DOWN;
    end

    always_comb begin
        spd_base  = (state_d != state_q) ? SPD_MIN_V : spd_q;
        fcnt_base = (state_d != state_q) ? '0 : fcnt_q;
        spd_d     = spd_base;
        fcnt_d    = fcnt_base;
        y_d       = paddle_y;
        y_up      = $signed({1'b0, paddle_y}) - $signed((Y_W+1)'(spd_base));
        y_dn      = $signed({1'b0, paddle_y}) + $signed((Y_W+1)'(spd_base));

        if (state_d == IDLE) begin
            spd_d  = SPD_MIN_V;
            fcnt_d = '0;
        end else if (frame_tick) begin
            if (state_d == UP)
                y_d = (y_up < Y_TOP_S) ? Y_TOP_S[Y_W-1:0] : y_up[Y_W-1:0];
            else
                y_d = (y_dn > Y_MAX_S) ? Y_MAX_S[Y_W-1:0] : y_dn[Y_W-1:0];

            if (fcnt_base == FC_LAST) begin
                fcnt_d = '0;
                if (spd_base < SPD_MAX_V)
                    spd_d = spd_base + 1'b1;
            end else begin
                fcnt_d = fcnt_base + 1'b1;
            end
        end
    end

    assign serve_d = acc_d.present && acc_d.code == KEY_SERVE &&
                     !(acc_q.present && acc_q.code == KEY_SERVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spd_q       <= SPD_MIN_V;
            fcnt_q      <= '0;
            paddle_y    <= Y_W'(Y_RESET);
            serve_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            spd_q       <= spd_d;
            fcnt_q      <= fcnt_d;
            paddle_y    <= y_d;
            serve_pulse <= serve_d;
        end
    end

    assign moving_up   = (state_q == UP);
    assign moving_down = (state_q == DOWN);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a 4-cycle debounce and a frame tick every 20 clocks.
`timescale 1ns/1ps
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keycode;
    logic       key_flag;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       moving_up, moving_down, serve_pulse;

    int errs   = 0;
    int checks = 0;
    int pulses = 0;

    always #20 clk = ~clk;

    paddle_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .keycode     (keycode),
        .key_flag    (key_flag),
        .frame_tick  (frame_tick),
        .paddle_y    (paddle_y),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .serve_pulse (serve_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (serve_pulse === 1'b1) pulses++;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            repeat (19) step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic press(input logic [4:0] code);
        key_flag = 1'b1;
        keycode  = code;
    endtask

    // Leave a stale "up" code on the bus to show it is ignored while key_flag is low.
    task automatic release_key();
        key_flag = 1'b0;
        keycode  = 5'd2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int acc_exp[10] = '{210, 212, 214, 216, 218, 220, 222, 224, 227, 230};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_flag = 1'b0; keycode = 5'd0; frame_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_y",     paddle_y,    208);
        chk("rst_up",    moving_up,   0);
        chk("rst_dn",    moving_down, 0);
        chk("rst_serve", serve_pulse, 0);

        // 3-cycle glitch must not be accepted
        press(5'd2);
        repeat (3) step();
        release_key();
        repeat (8) step();
        chk("bounce_up", moving_up, 0);
        frames(1);
        chk("bounce_y", paddle_y, 208);

        press(5'd2);
        repeat (3) step();
        chk("deb_before", moving_up, 0);
        step();
        chk("deb_at", moving_up, 1);
        chk("deb_y", paddle_y, 208);

        // accelerate up to speed 5, then flip to down
        frames(24);
        chk("flip_y24", paddle_y, 136);
        frames(1);
        chk("flip_y25", paddle_y, 131);
        press(5'd8);
        repeat (3) step();
        chk("flip_up_hold", moving_up, 1);
        chk("flip_dn_hold", moving_down, 0);
        step();
        chk("flip_up_fall", moving_up, 0);
        chk("flip_dn_rise", moving_down, 1);
        frames(1);
        chk("flip_first_dn", paddle_y, 133);

        release_key();
        do_reset();
        chk("rst2_y", paddle_y, 208);

        // acceleration and bottom clamp
        press(5'd8);
        repeat (4) step();
        chk("acc_dn", moving_down, 1);
        for (int i = 0; i < 10; i++) begin
            frames(1);
            chk($sformatf("acc_t%0d", i + 1), paddle_y, acc_exp[i]);
        end
        frames(36);
        chk("clamp_t46", paddle_y, 410);
        frames(1);
        chk("clamp_t47", paddle_y, 416);
        frames(1);
        chk("clamp_t48", paddle_y, 416);
        chk("clamp_dn", moving_down, 1);

        // reset while moving, coincident with a frame tick
        rst = 1'b1; frame_tick = 1'b1; key_flag = 1'b0;
        step();
        rst = 1'b0; frame_tick = 1'b0;
        chk("midrst_y",  paddle_y,    208);
        chk("midrst_dn", moving_down, 0);

        // top clamp: 6 - 7 must saturate at 0, not wrap
        press(5'd2);
        repeat (4) step();
        frames(46);
        chk("top_t46", paddle_y, 6);
        frames(1);
        chk("top_t47", paddle_y, 0);
        frames(1);
        chk("top_t48", paddle_y, 0);
        release_key();
        do_reset();

        // serve: one pulse per press, no motion
        pulses = 0;
        press(5'd5);
        frames(5);
        chk("serve_cnt1", pulses, 1);
        chk("serve_y1",   paddle_y, 208);
        chk("serve_up",   moving_up, 0);
        chk("serve_dn",   moving_down, 0);
        release_key();
        repeat (10) step();
        press(5'd5);
        frames(5);
        chk("serve_cnt2", pulses, 2);
        chk("serve_y2",   paddle_y, 208);
        release_key();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
